// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write-channel slave. AW and W are queued independently, paired in arrival order,
// window-decoded and handed one at a time to the register backend; B carries the outcome.

module axi_lite_write_slave_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             axi_clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
endmodule

module axi_lite_write_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter longint unsigned       ADDR_RANGE = 4096
) (
  input  logic                    axi_clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_ready,
  input  logic                    wr_err
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int W_W    = DATA_WIDTH + STRB_W;
  localparam logic [ADDR_WIDTH-1:0] RANGE_M1 = ADDR_WIDTH'(ADDR_RANGE - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_M  = ~ADDR_WIDTH'(STRB_W - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic                  rdy_en;
  logic                  aw_full;
  logic                  aw_empty;
  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] aw_head;
  logic [W_W-1:0]        w_head;
  logic [ADDR_WIDTH-1:0] win_off;
  logic                  in_win;
  logic                  b_free;
  logic                  issue;
  logic                  complete;
  logic                  aw_push;
  logic                  w_push;

  axi_lite_write_slave_fifo #(
    .WIDTH(ADDR_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_aw_fifo (
    .axi_clk  (axi_clk),
    .rst_n    (rst_n),
    .push     (aw_push),
    .push_data(AWADDR),
    .pop      (complete),
    .head     (aw_head),
    .full     (aw_full),
    .empty    (aw_empty)
  );

  axi_lite_write_slave_fifo #(
    .WIDTH(W_W),
    .DEPTH(FIFO_DEPTH)
  ) u_w_fifo (
    .axi_clk  (axi_clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_data({WDATA, WSTRB}),
    .pop      (complete),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // A full queue still accepts when its head leaves in the same cycle.
  assign AWREADY = rdy_en && (!aw_full || complete);
  assign WREADY  = rdy_en && (!w_full  || complete);
  assign aw_push = AWVALID && AWREADY;
  assign w_push  = WVALID  && WREADY;

  // BASE_ADDR is range-aligned, so addresses below it wrap to a large offset and miss.
  assign win_off = aw_head - BASE_ADDR;
  assign in_win  = ((win_off & ~RANGE_M1) == '0);

  assign b_free   = !BVALID || BREADY;
  assign issue    = !aw_empty && !w_empty && b_free;
  assign complete = issue && (!in_win || wr_ready);

  assign wr_en   = issue && in_win;
  assign wr_addr = win_off & ALIGN_M;
  assign wr_data = w_head[W_W-1:STRB_W];
  assign wr_strb = w_head[STRB_W-1:0];

  always_ff @(posedge axi_clk or negedge rst_n) begin
    if (!rst_n) begin
      BVALID <= 1'b0;
      BRESP  <= RESP_OKAY;
    end else if (complete) begin
      BVALID <= 1'b1;
      if (!in_win) begin
        BRESP <= RESP_DECERR;
      end else if (wr_err) begin
        BRESP <= RESP_SLVERR;
      end else begin
        BRESP <= RESP_OKAY;
      end
    end else if (BREADY) begin
      BVALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Directed bench for axi_lite_write_slave: vector table for single writes plus
// hand sequences for ordering, backend stall, B throttling and mid-flight reset.

module tb_axi_lite_write_slave;
  logic        axi_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [31:0] AWADDR  = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA   = '0;
  logic [3:0]  WSTRB   = '0;
  logic        WVALID  = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY  = 1'b1;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ready = 1'b1;
  logic        wr_err   = 1'b0;

  int checks   = 0;
  int failures = 0;

  axi_lite_write_slave dut (
    .axi_clk (axi_clk),
    .rst_n   (rst_n),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_ready(wr_ready),
    .wr_err  (wr_err)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        err;
    logic        exp_en;
    logic [31:0] exp_waddr;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  // Push one AW/W pair in the current cycle; both queues are expected to have room.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    AWADDR  = a;
    WDATA   = d;
    WSTRB   = s;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    @(negedge axi_clk);
    chk("pair_awready", AWREADY, 1'b1);
    chk("pair_wready", WREADY, 1'b1);
    step();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 32'h0000_0010, 2'b00};
    vecs[1] = '{32'h0000_0FFF, 32'h1234_5678, 4'h3, 1'b0, 1'b1, 32'h0000_0FFC, 2'b00};
    vecs[2] = '{32'h0000_2000, 32'h5555_AAAA, 4'hF, 1'b0, 1'b0, 32'h0000_0000, 2'b11};
    vecs[3] = '{32'h0000_1000, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0, 32'h0000_0000, 2'b11};
    vecs[4] = '{32'h0000_0007, 32'h7777_0000, 4'h0, 1'b1, 1'b1, 32'h0000_0004, 2'b10};
    vecs[5] = '{32'h0000_0000, 32'hA5A5_A5A5, 4'h8, 1'b0, 1'b1, 32'h0000_0000, 2'b00};

    // Reset values.
    #2;
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_wr_en", wr_en, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    chk("pre_edge_awready", AWREADY, 1'b0);
    step();
    chk("post_edge_awready", AWREADY, 1'b1);
    chk("post_edge_wready", WREADY, 1'b1);

    // Single writes, AW and W together, backend always ready.
    for (int i = 0; i < 6; i++) begin
      wr_err = vecs[i].err;
      push_pair(vecs[i].addr, vecs[i].data, vecs[i].strb);
      @(negedge axi_clk);
      chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].exp_en);
      if (vecs[i].exp_en) begin
        chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].exp_waddr);
        chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].data);
        chk($sformatf("v%0d_wr_strb", i), wr_strb, vecs[i].strb);
      end
      chk($sformatf("v%0d_bvalid_early", i), BVALID, 1'b0);
      step();
      @(negedge axi_clk);
      chk($sformatf("v%0d_bvalid", i), BVALID, 1'b1);
      chk($sformatf("v%0d_bresp", i), BRESP, vecs[i].exp_resp);
      chk($sformatf("v%0d_wr_en_after", i), wr_en, 1'b0);
      step();
    end
    wr_err = 1'b0;

    // W leads AW by several cycles.
    WDATA  = 32'h1111_1111;
    WSTRB  = 4'hF;
    WVALID = 1'b1;
    @(negedge axi_clk);
    chk("lead_wready", WREADY, 1'b1);
    step();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_clk);
      chk("lead_no_wr_en", wr_en, 1'b0);
      chk("lead_no_bvalid", BVALID, 1'b0);
      step();
    end
    AWADDR  = 32'h0000_0004;
    AWVALID = 1'b1;
    @(negedge axi_clk);
    chk("lead_awready", AWREADY, 1'b1);
    chk("lead_no_wr_en_hs", wr_en, 1'b0);
    step();
    AWVALID = 1'b0;
    @(negedge axi_clk);
    chk("lead_wr_en", wr_en, 1'b1);
    chk("lead_wr_addr", wr_addr, 32'h4);
    chk("lead_wr_data", wr_data, 32'h1111_1111);
    step();
    @(negedge axi_clk);
    chk("lead_bvalid", BVALID, 1'b1);
    chk("lead_bresp", BRESP, 2'b00);
    step();

    // Backend stall for 4 cycles, error reported on acceptance.
    wr_ready = 1'b0;
    wr_err   = 1'b1;
    push_pair(32'h0000_0020, 32'hCAFE_F00D, 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) wr_ready = 1'b1;
      @(negedge axi_clk);
      chk($sformatf("stall%0d_wr_en", i), wr_en, 1'b1);
      chk($sformatf("stall%0d_wr_addr", i), wr_addr, 32'h20);
      chk($sformatf("stall%0d_wr_data", i), wr_data, 32'hCAFE_F00D);
      chk($sformatf("stall%0d_bvalid", i), BVALID, 1'b0);
      step();
    end
    @(negedge axi_clk);
    chk("stall_bvalid", BVALID, 1'b1);
    chk("stall_bresp", BRESP, 2'b10);
    chk("stall_wr_en_after", wr_en, 1'b0);
    wr_err = 1'b0;
    step();

    // B throttled: one response pending, both queues fill, then drain back to back.
    BREADY = 1'b0;
    push_pair(32'h0000_0040, 32'h0000_00A1, 4'hF);
    push_pair(32'h0000_3000, 32'h0000_00B2, 4'hF);
    push_pair(32'h0000_0044, 32'h0000_00C3, 4'hF);
    @(negedge axi_clk);
    chk("thr_awready_full", AWREADY, 1'b0);
    chk("thr_wready_full", WREADY, 1'b0);
    chk("thr_bvalid", BVALID, 1'b1);
    chk("thr_bresp0", BRESP, 2'b00);
    chk("thr_no_wr_en", wr_en, 1'b0);
    step();
    BREADY = 1'b1;
    @(negedge axi_clk);
    chk("drain0_bvalid", BVALID, 1'b1);
    chk("drain0_bresp", BRESP, 2'b00);
    chk("drain0_awready", AWREADY, 1'b1);
    step();
    @(negedge axi_clk);
    chk("drain1_bvalid", BVALID, 1'b1);
    chk("drain1_bresp", BRESP, 2'b11);
    chk("drain1_wr_en", wr_en, 1'b1);
    chk("drain1_wr_addr", wr_addr, 32'h44);
    chk("drain1_wr_data", wr_data, 32'hC3);
    step();
    @(negedge axi_clk);
    chk("drain2_bvalid", BVALID, 1'b1);
    chk("drain2_bresp", BRESP, 2'b00);
    step();
    @(negedge axi_clk);
    chk("drain_done_bvalid", BVALID, 1'b0);
    step();

    // Reset while a response is pending and two pairs are queued.
    BREADY = 1'b0;
    push_pair(32'h0000_0050, 32'h0000_0001, 4'hF);
    push_pair(32'h0000_0054, 32'h0000_0002, 4'hF);
    push_pair(32'h0000_0058, 32'h0000_0003, 4'hF);
    @(negedge axi_clk);
    chk("prerst_bvalid", BVALID, 1'b1);
    chk("prerst_awready", AWREADY, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_bvalid", BVALID, 1'b0);
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_awready", AWREADY, 1'b0);
    chk("midrst_wready", WREADY, 1'b0);
    chk("midrst_bresp", BRESP, 2'b00);
    BREADY = 1'b1;
    step();
    @(negedge axi_clk);
    chk("inrst_wr_en", wr_en, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge axi_clk);
      chk($sformatf("postrst%0d_wr_en", i), wr_en, 1'b0);
      chk($sformatf("postrst%0d_bvalid", i), BVALID, 1'b0);
      step();
    end
    chk("postrst_awready", AWREADY, 1'b1);
    chk("postrst_wready", WREADY, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
